// File: rtl/wb_sel_pkg.sv
// -----------------------------------------------------------------------------
// wb_sel_pkg
// Shared definitions for the writeback-result selector:
//   - buf_state_e     : occupancy of the two-entry skid buffer
//   - DEFAULT_WIDTH   : default data width of each source and of the output
//   - DEFAULT_NUM_SRC : default number of candidate sources
//   - SRC_*           : named source indices used by the core
//   - sel_out_of_range: helper that flags a select beyond the populated sources
// -----------------------------------------------------------------------------
package wb_sel_pkg;

    localparam int DEFAULT_WIDTH   = 32;
    localparam int DEFAULT_NUM_SRC = 4;

    localparam int SRC_ALU  = 0;
    localparam int SRC_LOAD = 1;
    localparam int SRC_PC4  = 2;
    localparam int SRC_GEMM = 3;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b10
    } buf_state_e;

    // True when a select index addresses no populated source.
    function automatic logic sel_out_of_range(input int sel, input int num_src);
        return (sel >= num_src);
    endfunction

endpackage

// File: rtl/wb_select_pipe_mux.sv
// -----------------------------------------------------------------------------
// mux_nx1
// Purely combinational N-to-1 selector. Built as an AND-OR tree so that a
// select with no matching source (index >= NUM_SRC) produces all zeros.
// Parameters:
//   WIDTH   - width of each source word
//   NUM_SRC - number of sources (need not be a power of two)
// Ports:
//   in_data  - flattened sources, source k at [k*WIDTH +: WIDTH]
//   sel      - source index
//   out_data - selected word, zero when sel is out of range
// -----------------------------------------------------------------------------
module mux_nx1 #(
    parameter int  WIDTH   = 32,
    parameter int  NUM_SRC = 4,
    localparam int SEL_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]         sel,
    output logic [WIDTH-1:0]         out_data
);

    logic [WIDTH-1:0] mux_data_s;

    // AND-OR select: each source contributes only when its index matches.
    always_comb begin
        mux_data_s = {WIDTH{1'b0}};
        for (int k = 0; k < NUM_SRC; k++) begin
            mux_data_s = mux_data_s |
                         (in_data[k*WIDTH +: WIDTH] & {WIDTH{sel == SEL_W'(k)}});
        end
    end

    assign out_data = mux_data_s;

endmodule

// File: rtl/wb_select_pipe.sv
// -----------------------------------------------------------------------------
// wb_select_pipe
// Writeback-result selector: picks one of NUM_SRC candidate results and
// registers it into a two-entry valid/ready skid buffer (head + skid).
// Optional feature macro: WB_SEL_ERR_EN adds a sticky out-of-range select flag.
// Parameters:
//   WIDTH   - data width
//   NUM_SRC - number of sources (>= 2)
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   in_data   - flattened sources, source k at [k*WIDTH +: WIDTH]
//   in_sel    - source index
//   in_valid  - upstream offers a result
//   in_ready  - buffer can accept (registered, not FULL)
//   flush     - synchronous discard of all buffered results
//   out_data  - head of buffer
//   out_valid - head holds a valid word (registered, not EMPTY)
//   out_ready - writeback consumes the head this cycle
//   sel_err   - sticky out-of-range select flag (WB_SEL_ERR_EN only)
// -----------------------------------------------------------------------------
module wb_select_pipe
    import wb_sel_pkg::*;
#(
    parameter int  WIDTH   = DEFAULT_WIDTH,
    parameter int  NUM_SRC = DEFAULT_NUM_SRC,
    localparam int SEL_W   = $clog2(NUM_SRC)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_SRC*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     flush,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
`ifdef WB_SEL_ERR_EN
    output logic                     sel_err,
`endif
    input  logic                     out_ready
);

    logic [WIDTH-1:0] mux_data_s;
    logic             accept_s;
    logic             drain_s;

    buf_state_e       state_r;
    buf_state_e       state_nxt_s;
    logic [WIDTH-1:0] head_r;
    logic [WIDTH-1:0] head_nxt_s;
    logic [WIDTH-1:0] skid_r;
    logic [WIDTH-1:0] skid_nxt_s;
    logic             in_ready_r;
    logic             out_valid_r;

    mux_nx1 #(
        .WIDTH   (WIDTH),
        .NUM_SRC (NUM_SRC)
    ) u_mux (
        .in_data  (in_data),
        .sel      (in_sel),
        .out_data (mux_data_s)
    );

    // Handshakes use only registered flags, so in_ready never depends on out_ready.
    assign accept_s = in_valid & in_ready_r;
    assign drain_s  = out_valid_r & out_ready;

    // Next-state and datapath selection for the head/skid buffer.
    always_comb begin
        state_nxt_s = state_r;
        head_nxt_s  = head_r;
        skid_nxt_s  = skid_r;
        if (flush) begin
            // Flush wins over any accept or drain in the same cycle.
            state_nxt_s = EMPTY;
            head_nxt_s  = {WIDTH{1'b0}};
            skid_nxt_s  = {WIDTH{1'b0}};
        end else begin
            case (state_r)
                EMPTY: begin
                    if (accept_s) begin
                        state_nxt_s = ONE;
                        head_nxt_s  = mux_data_s;
                    end else begin
                        state_nxt_s = EMPTY;
                    end
                end
                ONE: begin
                    if (accept_s && !drain_s) begin
                        state_nxt_s = FULL;
                        skid_nxt_s  = mux_data_s;
                    end else if (accept_s && drain_s) begin
                        // Head leaves and the new word takes its place.
                        state_nxt_s = ONE;
                        head_nxt_s  = mux_data_s;
                    end else if (drain_s) begin
                        state_nxt_s = EMPTY;
                    end else begin
                        state_nxt_s = ONE;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only a drain can change occupancy.
                    if (drain_s) begin
                        state_nxt_s = ONE;
                        head_nxt_s  = skid_r;
                        skid_nxt_s  = {WIDTH{1'b0}};
                    end else begin
                        state_nxt_s = FULL;
                    end
                end
                default: begin
                    state_nxt_s = EMPTY;
                    head_nxt_s  = {WIDTH{1'b0}};
                    skid_nxt_s  = {WIDTH{1'b0}};
                end
            endcase
        end
    end

    // Buffer state, data and handshake flags; flags are decoded from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= EMPTY;
            head_r      <= {WIDTH{1'b0}};
            skid_r      <= {WIDTH{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            head_r      <= head_nxt_s;
            skid_r      <= skid_nxt_s;
            in_ready_r  <= (state_nxt_s != FULL);
            out_valid_r <= (state_nxt_s != EMPTY);
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = head_r;

`ifdef WB_SEL_ERR_EN
    logic sel_err_r;
    logic sel_oor_s;

    assign sel_oor_s = sel_out_of_range(int'(in_sel), NUM_SRC);

    // Sticky flag: set by any accept with an unpopulated select, cleared only by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_err_r <= 1'b0;
        end else begin
            sel_err_r <= sel_err_r | (accept_s & sel_oor_s);
        end
    end

    assign sel_err = sel_err_r;
`endif

endmodule

// File: tb/tb_wb_select_pipe.sv
// -----------------------------------------------------------------------------
// tb_wb_select_pipe
// Directed bench for wb_select_pipe. Instance dut_a uses NUM_SRC=4, instance
// dut_b uses NUM_SRC=3 so that select index 3 is out of range.
// -----------------------------------------------------------------------------
module tb_wb_select_pipe;
    import wb_sel_pkg::*;

    localparam logic [31:0] V_ALU  = 32'h0233_3333;
    localparam logic [31:0] V_LOAD = 32'h0000_2034;
    localparam logic [31:0] V_PC4  = 32'h0123_4567;
    localparam logic [31:0] V_GEMM = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst;

    logic [127:0] a_in_data;
    logic [1:0]   a_in_sel;
    logic         a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready;
    logic [31:0]  a_out_data;

    logic [95:0]  b_in_data;
    logic [1:0]   b_in_sel;
    logic         b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready;
    logic [31:0]  b_out_data;

`ifdef WB_SEL_ERR_EN
    logic a_sel_err, b_sel_err;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    wb_select_pipe #(.WIDTH(32), .NUM_SRC(4)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_data   (a_in_data),
        .in_sel    (a_in_sel),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .flush     (a_flush),
        .out_data  (a_out_data),
        .out_valid (a_out_valid),
`ifdef WB_SEL_ERR_EN
        .sel_err   (a_sel_err),
`endif
        .out_ready (a_out_ready)
    );

    wb_select_pipe #(.WIDTH(32), .NUM_SRC(3)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_data   (b_in_data),
        .in_sel    (b_in_sel),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .flush     (b_flush),
        .out_data  (b_out_data),
        .out_valid (b_out_valid),
`ifdef WB_SEL_ERR_EN
        .sel_err   (b_sel_err),
`endif
        .out_ready (b_out_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_in_data = '0; a_in_sel = 2'd0; a_in_valid = 1'b0; a_flush = 1'b0; a_out_ready = 1'b0;
        b_in_data = '0; b_in_sel = 2'd0; b_in_valid = 1'b0; b_flush = 1'b0; b_out_ready = 1'b0;
        #2;
        total_cnt++; if (a_out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", a_out_valid); else pass_cnt++;
        total_cnt++; if (a_out_data !== 32'h0) $display("FAIL reset_out_data: got %h want 00000000", a_out_data); else pass_cnt++;
        total_cnt++; if (a_in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", a_in_ready); else pass_cnt++;
        total_cnt++; if (b_out_valid !== 1'b0) $display("FAIL reset_b_out_valid: got %b want 0", b_out_valid); else pass_cnt++;
`ifdef WB_SEL_ERR_EN
        total_cnt++; if (a_sel_err !== 1'b0) $display("FAIL reset_sel_err: got %b want 0", a_sel_err); else pass_cnt++;
`endif
        tick();
        rst = 1'b0;
        tick();
        total_cnt++; if (a_out_valid !== 1'b0) $display("FAIL post_reset_idle: got %b want 0", a_out_valid); else pass_cnt++;
    endtask

    task automatic test_basic_select();
        logic [31:0] exp_w [4];
        exp_w[0] = V_ALU; exp_w[1] = V_LOAD; exp_w[2] = V_PC4; exp_w[3] = V_GEMM;
        a_in_data   = {V_GEMM, V_PC4, V_LOAD, V_ALU};
        a_out_ready = 1'b1;
        a_in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_in_sel = 2'(i);
            tick();
            total_cnt++; if (a_out_data !== exp_w[i]) $display("FAIL basic_data[%0d]: got %h want %h", i, a_out_data, exp_w[i]); else pass_cnt++;
            total_cnt++; if (a_out_valid !== 1'b1) $display("FAIL basic_valid[%0d]: got %b want 1", i, a_out_valid); else pass_cnt++;
        end
        a_in_valid = 1'b0;
        tick();
        total_cnt++; if (a_out_valid !== 1'b0) $display("FAIL basic_drain_empty: got %b want 0", a_out_valid); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        a_in_data   = {V_GEMM, V_PC4, V_LOAD, V_ALU};
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_sel    = 2'(SRC_ALU);
        total_cnt++; if (a_in_ready !== 1'b1) $display("FAIL bp_ready_1st: got %b want 1", a_in_ready); else pass_cnt++;
        tick();
        a_in_sel = 2'(SRC_LOAD);
        total_cnt++; if (a_in_ready !== 1'b1) $display("FAIL bp_ready_2nd: got %b want 1", a_in_ready); else pass_cnt++;
        tick();
        a_in_sel = 2'(SRC_PC4);
        total_cnt++; if (a_in_ready !== 1'b0) $display("FAIL bp_ready_3rd: got %b want 0", a_in_ready); else pass_cnt++;
        total_cnt++; if (a_out_data !== V_ALU) $display("FAIL bp_head_full: got %h want %h", a_out_data, V_ALU); else pass_cnt++;
        tick();
        total_cnt++; if (a_out_data !== V_ALU) $display("FAIL bp_hold_data: got %h want %h", a_out_data, V_ALU); else pass_cnt++;
        total_cnt++; if (a_out_valid !== 1'b1) $display("FAIL bp_hold_valid: got %b want 1", a_out_valid); else pass_cnt++;
        a_out_ready = 1'b1;
        tick();
        total_cnt++; if (a_out_data !== V_LOAD) $display("FAIL bp_second_word: got %h want %h", a_out_data, V_LOAD); else pass_cnt++;
        total_cnt++; if (a_in_ready !== 1'b1) $display("FAIL bp_ready_reassert: got %b want 1", a_in_ready); else pass_cnt++;
        tick();
        total_cnt++; if (a_out_data !== V_PC4) $display("FAIL bp_third_word: got %h want %h", a_out_data, V_PC4); else pass_cnt++;
        a_in_valid = 1'b0;
        tick();
        total_cnt++; if (a_out_valid !== 1'b0) $display("FAIL bp_final_empty: got %b want 0", a_out_valid); else pass_cnt++;
    endtask

    task automatic test_accept_drain();
        logic [31:0] exp_d;
        a_out_ready = 1'b1;
        a_in_valid  = 1'b1;
        for (int i = 0; i < 9; i++) begin
            a_in_sel  = 2'(i % 3);
            a_in_data = {32'h4000_0000 + 32'(i), 32'h3000_0000 + 32'(i),
                         32'h2000_0000 + 32'(i), 32'h1000_0000 + 32'(i)};
            exp_d = 32'h1000_0000 * 32'((i % 3) + 1) + 32'(i);
            tick();
            total_cnt++; if (a_out_data !== exp_d) $display("FAIL ad_data[%0d]: got %h want %h", i, a_out_data, exp_d); else pass_cnt++;
            total_cnt++; if (a_out_valid !== 1'b1) $display("FAIL ad_valid[%0d]: got %b want 1", i, a_out_valid); else pass_cnt++;
            total_cnt++; if (a_in_ready !== 1'b1) $display("FAIL ad_ready[%0d]: got %b want 1", i, a_in_ready); else pass_cnt++;
        end
        a_in_valid = 1'b0;
        tick();
        total_cnt++; if (a_out_valid !== 1'b0) $display("FAIL ad_final_empty: got %b want 0", a_out_valid); else pass_cnt++;
    endtask

    task automatic test_flush();
        a_in_data   = {32'hDEAD_BEEF, V_PC4, V_LOAD, V_ALU};
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_sel    = 2'(SRC_ALU);
        tick();
        a_in_sel = 2'(SRC_LOAD);
        tick();
        total_cnt++; if (a_in_ready !== 1'b0) $display("FAIL flush_pre_full: got %b want 0", a_in_ready); else pass_cnt++;
        a_flush     = 1'b1;
        a_out_ready = 1'b1;
        a_in_sel    = 2'(SRC_GEMM);
        tick();
        a_flush    = 1'b0;
        a_in_valid = 1'b0;
        total_cnt++; if (a_out_valid !== 1'b0) $display("FAIL flush_out_valid: got %b want 0", a_out_valid); else pass_cnt++;
        total_cnt++; if (a_in_ready !== 1'b1) $display("FAIL flush_in_ready: got %b want 1", a_in_ready); else pass_cnt++;
        total_cnt++; if (a_out_data !== 32'h0) $display("FAIL flush_out_data: got %h want 00000000", a_out_data); else pass_cnt++;
        tick();
        total_cnt++; if (a_out_valid !== 1'b0) $display("FAIL flush_no_ghost: got %b want 0", a_out_valid); else pass_cnt++;
        total_cnt++; if (a_out_data !== 32'h0) $display("FAIL flush_no_ghost_data: got %h want 00000000", a_out_data); else pass_cnt++;
    endtask

    task automatic test_out_of_range();
        b_in_data   = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        b_out_ready = 1'b1;
        b_in_valid  = 1'b1;
        b_in_sel    = 2'd3;
        tick();
        total_cnt++; if (b_out_data !== 32'h0) $display("FAIL oor_data: got %h want 00000000", b_out_data); else pass_cnt++;
        total_cnt++; if (b_out_valid !== 1'b1) $display("FAIL oor_valid: got %b want 1", b_out_valid); else pass_cnt++;
`ifdef WB_SEL_ERR_EN
        total_cnt++; if (b_sel_err !== 1'b1) $display("FAIL oor_sel_err_set: got %b want 1", b_sel_err); else pass_cnt++;
`endif
        b_in_sel = 2'd2;
        tick();
        total_cnt++; if (b_out_data !== 32'h3333_3333) $display("FAIL oor_last_src: got %h want 33333333", b_out_data); else pass_cnt++;
        b_in_valid = 1'b0;
        b_flush    = 1'b1;
        tick();
        b_flush = 1'b0;
        total_cnt++; if (b_out_valid !== 1'b0) $display("FAIL oor_flush_valid: got %b want 0", b_out_valid); else pass_cnt++;
`ifdef WB_SEL_ERR_EN
        total_cnt++; if (b_sel_err !== 1'b1) $display("FAIL oor_sel_err_sticky: got %b want 1", b_sel_err); else pass_cnt++;
        total_cnt++; if (a_sel_err !== 1'b0) $display("FAIL oor_sel_err_other: got %b want 0", a_sel_err); else pass_cnt++;
`endif
    endtask

    task automatic test_async_reset();
        a_in_data   = {V_GEMM, V_PC4, V_LOAD, V_ALU};
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_sel    = 2'(SRC_ALU);
        tick();
        a_in_sel = 2'(SRC_PC4);
        tick();
        a_in_valid = 1'b0;
        total_cnt++; if (a_out_valid !== 1'b1) $display("FAIL arst_pre_valid: got %b want 1", a_out_valid); else pass_cnt++;
        total_cnt++; if (a_in_ready !== 1'b0) $display("FAIL arst_pre_full: got %b want 0", a_in_ready); else pass_cnt++;
        #2;
        rst = 1'b1;
        #1;
        total_cnt++; if (a_out_valid !== 1'b0) $display("FAIL arst_out_valid: got %b want 0", a_out_valid); else pass_cnt++;
        total_cnt++; if (a_in_ready !== 1'b1) $display("FAIL arst_in_ready: got %b want 1", a_in_ready); else pass_cnt++;
        total_cnt++; if (a_out_data !== 32'h0) $display("FAIL arst_out_data: got %h want 00000000", a_out_data); else pass_cnt++;
`ifdef WB_SEL_ERR_EN
        total_cnt++; if (b_sel_err !== 1'b0) $display("FAIL arst_sel_err_clear: got %b want 0", b_sel_err); else pass_cnt++;
`endif
        tick();
        rst = 1'b0;
        tick();
        total_cnt++; if (a_out_valid !== 1'b0) $display("FAIL arst_post_empty: got %b want 0", a_out_valid); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic_select();
        test_backpressure();
        test_accept_drain();
        test_flush();
        test_out_of_range();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
